if_stage: RTL and testbench

Instruction-fetch stage of the RV32I core: owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for the decoder. It accepts stall requests from the hazard unit and branch/jump redirects from execute.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/if_stage_pc_reg.sv | 40 ++++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and the IF/ID pipeline-register record.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Address increment between sequential instruction words.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // addi x0,x0,0 : the canonical bubble in the pipeline.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Contents of the IF/ID pipeline register handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
    logic            misalign;
  } ifid_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register for the fetch stage.
// Priority each cycle: rst > redirect > stall > advance by one word.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_tgt,  // already word-aligned by the caller
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next-PC selection; sequential adds wrap modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (!stall) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: drives the fetch address from the PC,
// captures the combinational memory response into the IF/ID register,
// and handles hazard stalls and execute-stage redirects.
// Optional build macro IF_MISALIGN_TRAP_EN: flags the first instruction
// fetched after a redirect whose target had nonzero low address bits.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instr_addr,
  input  logic [XLEN-1:0] r_data,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic [XLEN-1:0] instr_d,
  output logic            valid_d,
  output logic            misalign_d
);

  logic [XLEN-1:0] pc_cur;
  ifid_t           ifid_q;
  ifid_t           ifid_d;
  logic            misalign_pend;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_tgt (word_align(redirect_pc)),
    .pc_o         (pc_cur)
  );

  assign instr_addr = pc_cur;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_pend_q;
  logic misalign_pend_d;

  // Remember a misaligned redirect until its target instruction is captured;
  // a newer redirect replaces the pending flag with its own alignment check.
  always_comb begin
    misalign_pend_d = misalign_pend_q;
    if (redirect) begin
      misalign_pend_d = |redirect_pc[1:0];
    end else if (!stall) begin
      misalign_pend_d = 1'b0;
    end
  end

  // Pending-misalign flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_pend_q <= 1'b0;
    end else begin
      misalign_pend_q <= misalign_pend_d;
    end
  end

  assign misalign_pend = misalign_pend_q;
`else
  // Low target bits are intentionally discarded in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_pend        = 1'b0;
`endif

  // IF/ID next-state: redirect flushes to a bubble, stall holds, else capture.
  always_comb begin
    ifid_d = ifid_q;
    if (redirect) begin
      ifid_d.instr    = NOP_INSTR;
      ifid_d.valid    = 1'b0;
      ifid_d.misalign = 1'b0;
    end else if (!stall) begin
      ifid_d.pc       = pc_cur;
      ifid_d.pc_plus4 = pc_cur + PC_STEP;
      ifid_d.instr    = r_data;
      ifid_d.valid    = 1'b1;
      ifid_d.misalign = misalign_pend;
    end
  end

  // IF/ID pipeline register; reset leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.valid    <= 1'b0;
      ifid_q.misalign <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign pc_d       = ifid_q.pc;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign instr_d    = ifid_q.instr;
  assign valid_d    = ifid_q.valid;
  assign misalign_d = ifid_q.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a combinational instruction memory model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_addr;
  logic [31:0] r_data;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        misalign_d;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  always #5 clk = ~clk;

  // Memory model: word 0 holds addi x1,x0,5; other words are address-tagged.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'hA5A5_0013;
  endfunction

  assign r_data = mem_rd(instr_addr);

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_addr  (instr_addr),
    .r_data      (r_data),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .instr_d     (instr_d),
    .valid_d     (valid_d),
    .misalign_d  (misalign_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    step();
    chk("rst_addr",   instr_addr, 32'h0);
    chk("rst_valid",  {31'b0, valid_d}, 32'h0);
    chk("rst_instr",  instr_d, 32'h13);
    chk("rst_pc",     pc_d, 32'h0);
    chk("rst_pc4",    pc_plus4_d, 32'h0);
    chk("rst_mis",    {31'b0, misalign_d}, 32'h0);

    rst = 1'b0;
    step();
    chk("f0_instr", instr_d, 32'h0050_0093);
    chk("f0_pc",    pc_d, 32'h0);
    chk("f0_pc4",   pc_plus4_d, 32'h4);
    chk("f0_valid", {31'b0, valid_d}, 32'h1);
    chk("f0_addr",  instr_addr, 32'h4);
    step();
    chk("f1_pc",    pc_d, 32'h4);
    chk("f1_instr", instr_d, mem_rd(32'h4));
    chk("f1_addr",  instr_addr, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  instr_addr, 32'h8);
      chk("stall_pc",    pc_d, 32'h4);
      chk("stall_instr", instr_d, mem_rd(32'h4));
      chk("stall_valid", {31'b0, valid_d}, 32'h1);
    end
    stall = 1'b0;
    step();
    chk("rel_pc",    pc_d, 32'h8);
    chk("rel_instr", instr_d, mem_rd(32'h8));
    chk("rel_addr",  instr_addr, 32'hC);
    step();
    chk("seq_pc12",  pc_d, 32'hC);
    chk("seq_addr16", instr_addr, 32'h10);
    step();
    chk("seq_pc16",  pc_d, 32'h10);
    chk("seq_addr20", instr_addr, 32'h14);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
    step();
    chk("rd_addr",  instr_addr, 32'h40);
    chk("rd_valid", {31'b0, valid_d}, 32'h0);
    chk("rd_instr", instr_d, 32'h13);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("rd_pc",    pc_d, 32'h40);
    chk("rd_pc4",   pc_plus4_d, 32'h44);
    chk("rd_tinst", instr_d, mem_rd(32'h40));
    chk("rd_v1",    {31'b0, valid_d}, 32'h1);
    chk("rd_addr2", instr_addr, 32'h44);

    redirect = 1'b1; redirect_pc = 32'h22;
    step();
    chk("mis_addr",  instr_addr, 32'h20);
    chk("mis_bub",   {31'b0, valid_d}, 32'h0);
    chk("mis_bubm",  {31'b0, misalign_d}, 32'h0);
    redirect = 1'b0;
    step();
    chk("mis_pc",    pc_d, 32'h20);
    chk("mis_flag",  {31'b0, misalign_d}, {31'b0, EXP_MIS});
    step();
    chk("mis_pc24",  pc_d, 32'h24);
    chk("mis_clr",   {31'b0, misalign_d}, 32'h0);

    redirect = 1'b1; redirect_pc = 32'h31;
    step();
    redirect_pc = 32'h50;
    step();
    redirect = 1'b0;
    step();
    chk("ovw_pc",   pc_d, 32'h50);
    chk("ovw_mis",  {31'b0, misalign_d}, 32'h0);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h63;
    step();
    redirect = 1'b0;
    step();
    chk("mstall_hold", {31'b0, misalign_d}, 32'h0);
    stall = 1'b0;
    step();
    chk("mstall_pc",  pc_d, 32'h60);
    chk("mstall_mis", {31'b0, misalign_d}, {31'b0, EXP_MIS});

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", instr_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk("wrap_pc",   pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4",  pc_plus4_d, 32'h0);
    chk("wrap_inst", instr_d, mem_rd(32'hFFFF_FFFC));
    chk("wrap_addr0", instr_addr, 32'h0);

    step();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; rst = 1'b1;
    step();
    chk("rstmid_addr",  instr_addr, 32'h0);
    chk("rstmid_valid", {31'b0, valid_d}, 32'h0);
    chk("rstmid_pc",    pc_d, 32'h0);
    chk("rstmid_instr", instr_d, 32'h13);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    chk("rstrel_pc",    pc_d, 32'h0);
    chk("rstrel_valid", {31'b0, valid_d}, 32'h1);
    chk("rstrel_instr", instr_d, 32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
